// File: rtl/parallel_mul_pkg.sv
// Shared types and defaults for the parallel vector multiplier.
// FSM state encoding and default lane geometry.
package parallel_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_DONE
  } state_t;

  localparam int DEF_N_LANES = 5;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_FRAC    = 16;

endpackage

// File: rtl/mul_seq.sv
// One lane of the vector multiplier: unsigned shift-add, one b bit per step.
// Result is the fixed-point window of the full product, saturated on overflow.
module mul_seq
  import parallel_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_res,
  output logic             o_sat
);

  logic [2*WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] w_sum;
  logic [2*WIDTH-1:0] w_hi;

  // Partial product including the bit consumed by the current step.
  // Once all b bits are shifted out this equals the registered product.
  assign w_sum = r_prod + (r_b[0] ? r_a : '0);
  assign w_hi  = w_sum >> (FRAC + WIDTH);
  assign o_sat = |w_hi;
  assign o_res = o_sat ? '1 : w_sum[FRAC +: WIDTH];

  // Operand load and one shift-add step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
    end else if (i_load) begin
      r_a    <= {{WIDTH{1'b0}}, i_a};
      r_b    <= i_b;
      r_prod <= '0;
    end else if (i_step) begin
      r_prod <= w_sum;
      r_a    <= r_a << 1;
      r_b    <= r_b >> 1;
    end
  end

endmodule

// File: rtl/parallel_vec_mul.sv
// N-lane fixed-point vector multiplier with optional saturating dot product.
// Lanes multiply concurrently; the dot sum walks the lane results serially.
module parallel_vec_mul
  import parallel_mul_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FRAC    = DEF_FRAC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [N_LANES*WIDTH-1:0] a_flat,
  input  logic [N_LANES*WIDTH-1:0] b_flat,
  output logic [N_LANES*WIDTH-1:0] x_flat,
  output logic [WIDTH-1:0]         dot,
  output logic                     valid,
  output logic                     busy,
  output logic                     ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(N_LANES + 1);

  state_t                          r_state;
  logic                            r_mode;
  logic [CW-1:0]                   r_cnt;
  logic [IW-1:0]                   r_idx;
  logic [WIDTH-1:0]                r_acc;
  logic                            r_asat;

  logic                            w_accept;
  logic                            w_step;
  logic [N_LANES-1:0][WIDTH-1:0]   w_res;
  logic [N_LANES-1:0]              w_sat;
  logic [WIDTH-1:0]                w_lane;
  logic [WIDTH:0]                  w_add;
  logic [WIDTH-1:0]                w_acc_nxt;

  assign w_accept = start &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_step   = (r_state == S_MUL);

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    mul_seq #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_lane (
      .clk    (clk),
      .rst_n  (reset),
      .i_load (w_accept),
      .i_step (w_step),
      .i_a    (a_flat[g*WIDTH +: WIDTH]),
      .i_b    (b_flat[g*WIDTH +: WIDTH]),
      .o_res  (w_res[g]),
      .o_sat  (w_sat[g])
    );
  end

  // Saturating add of the current lane result into the running sum.
  assign w_lane    = x_flat[int'(r_idx)*WIDTH +: WIDTH];
  assign w_add     = {1'b0, r_acc} + {1'b0, w_lane};
  assign w_acc_nxt = w_add[WIDTH] ? '1 : w_add[WIDTH-1:0];

  // Control FSM, lane result capture and serial dot accumulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_asat  <= 1'b0;
      x_flat  <= '0;
      dot     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mode  <= mode;
            r_cnt   <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_MUL;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            x_flat <= w_res;
            ovf    <= |w_sat;
            if (r_mode) begin
              r_idx   <= '0;
              r_acc   <= '0;
              r_asat  <= 1'b0;
              r_state <= S_ACC;
            end else begin
              busy    <= 1'b0;
              valid   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_ACC: begin
          r_acc  <= w_acc_nxt;
          r_asat <= r_asat | w_add[WIDTH];
          r_idx  <= r_idx + 1'b1;
          if (r_idx == IW'(N_LANES - 1)) begin
            dot     <= w_acc_nxt;
            ovf     <= ovf | r_asat | w_add[WIDTH];
            busy    <= 1'b0;
            valid   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_vec_mul.sv
// Directed bench for parallel_vec_mul at default geometry (5 x Q16.16).
// Cycle n spans edge n-1 to edge n; start is accepted at edge 0.
module tb_parallel_vec_mul;

  localparam int N = 5;
  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic           start;
  logic           mode;
  logic [N*W-1:0] a_flat;
  logic [N*W-1:0] b_flat;
  logic [N*W-1:0] x_flat;
  logic [W-1:0]   dot;
  logic           valid;
  logic           busy;
  logic           ovf;

  int n_chk;
  int n_err;

  parallel_vec_mul dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .x_flat (x_flat),
    .dot    (dot),
    .valid  (valid),
    .busy   (busy),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           mode;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N*W-1:0] x;
    logic [W-1:0]   dot;
    logic           ovf;
    int             lat;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [N*W-1:0] pk(
    input logic [W-1:0] v0, input logic [W-1:0] v1,
    input logic [W-1:0] v2, input logic [W-1:0] v3,
    input logic [W-1:0] v4);
    return {v4, v3, v2, v1, v0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns in the DONE cycle (posedge+1).
  task automatic run_op(input logic m, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, output int lat);
    mode   = m;
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k + 1;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL valid_timeout: got none expected valid");
    end else begin
      chk("busy_at_valid", 64'(busy), 64'd0);
    end
  endtask

  task automatic chk_vec(input vec_t v, input int lat);
    chk({v.name, "_lat"}, 64'(lat), 64'(v.lat));
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_x%0d", v.name, i),
          64'(x_flat[i*W +: W]), 64'(v.x[i*W +: W]));
    chk({v.name, "_dot"}, 64'(dot), 64'(v.dot));
    chk({v.name, "_ovf"}, 64'(ovf), 64'(v.ovf));
  endtask

  initial begin
    int lat;
    int nv;
    n_chk  = 0;
    n_err  = 0;
    reset  = 1'b0;
    start  = 1'b0;
    mode   = 1'b0;
    a_flat = '0;
    b_flat = '0;

    vecs[0] = '{"ew", 1'b0,
      pk(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 32'h00050000),
      pk(32'h00070000, 32'h00080000, 32'h00090000, 32'h000A0000, 32'h000B0000),
      pk(32'h00070000, 32'h00100000, 32'h001B0000, 32'h00280000, 32'h00370000),
      32'h0, 1'b0, 33};
    vecs[1] = '{"dot", 1'b1, vecs[0].a, vecs[0].b, vecs[0].x,
      32'h00910000, 1'b0, 38};
    vecs[2] = '{"lsat", 1'b0,
      pk(32'h80000000, 32'h00020000, 32'h00030000, 32'h00040000, 32'h00050000),
      pk(32'h00020000, 32'h00080000, 32'h00090000, 32'h000A0000, 32'h000B0000),
      pk(32'hFFFFFFFF, 32'h00100000, 32'h001B0000, 32'h00280000, 32'h00370000),
      32'h00910000, 1'b1, 33};
    vecs[3] = '{"dsat", 1'b1,
      {N{32'hFFFF0000}}, {N{32'h00010000}}, {N{32'hFFFF0000}},
      32'hFFFFFFFF, 1'b1, 38};
    vecs[4] = '{"zero", 1'b1,
      pk(32'h0, 32'h00018000, 32'h0, 32'h00020000, 32'h00008000),
      pk(32'h00030000, 32'h0, 32'h00040000, 32'h00004000, 32'h00008000),
      pk(32'h0, 32'h0, 32'h0, 32'h00008000, 32'h00004000),
      32'h0000C000, 1'b0, 38};
    vecs[5] = '{"trunc", 1'b0,
      pk(32'h00000001, 32'h00018000, 32'hFFFFFFFF, 32'h00010000, 32'h00000003),
      pk(32'h00008000, 32'h00018000, 32'h00010000, 32'hFFFFFFFF, 32'h00000003),
      pk(32'h0, 32'h00024000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0),
      32'h0000C000, 1'b0, 33};

    #12;
    chk("rst_x", 64'(x_flat[W-1:0]), 64'd0);
    chk("rst_dot", 64'(dot), 64'd0);
    chk("rst_flags", 64'({valid, busy, ovf}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].mode, vecs[v].a, vecs[v].b, lat);
      chk_vec(vecs[v], lat);
      @(posedge clk); #1;
      chk({vecs[v].name, "_hold_dot"}, 64'(dot), 64'(vecs[v].dot));
    end

    run_op(1'b0, vecs[0].a, vecs[0].b, lat);
    run_op(1'b1, vecs[1].a, vecs[1].b, lat);
    chk_vec(vecs[1], lat);
    @(posedge clk); #1;

    mode   = 1'b0;
    a_flat = vecs[0].a;
    b_flat = vecs[0].b;
    start  = 1'b1;
    nv     = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (valid) nv++;
      if (k == 31) start = 1'b0;
    end
    chk("start_held_valids", 64'(nv), 64'd1);
    chk("start_held_x4", 64'(x_flat[4*W +: W]), 64'h00370000);

    mode   = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_x", 64'(|x_flat), 64'd0);
    chk("mid_rst_dot", 64'(dot), 64'd0);
    chk("mid_rst_flags", 64'({valid, busy, ovf}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    nv = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (valid || busy) nv++;
    end
    chk("post_rst_quiet", 64'(nv), 64'd0);
    run_op(vecs[0].mode, vecs[0].a, vecs[0].b, lat);
    chk_vec(vecs[0], lat);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
